// File: rtl/adder_arbiter.sv
// adder_arbiter: one shared WIDTH-bit add/sub unit, round-robin
// arbitrated between NUM_REQ requesters, with a single result register.
module adder_arbiter #(
   parameter int  WIDTH   = 32,
   parameter int  NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] op_a,
   input  logic [NUM_REQ*WIDTH-1:0] op_b,
   input  logic [NUM_REQ-1:0]       sub,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [WIDTH-1:0]         rsp_sum,
   output logic                     rsp_cout,
   output logic                     rsp_ovf
);

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             valid_q, valid_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             free;
   logic             win_found;
   logic [IDW-1:0]   win_idx;
   logic             grant_en;

   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic             s_sel;
   logic [WIDTH-1:0] b_mod;
   logic [WIDTH:0]   full;
   logic             ovf_c;

   // Round-robin search: first pending request at or above ptr, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = IDW'(idx);
         end
      end
   end

   // Grant only when the result slot can take a new value this cycle.
   always_comb begin
      free     = !valid_q || rsp_ready;
      grant_en = free && !reset && win_found;
      grant    = '0;
      if (grant_en) begin
         grant = NUM_REQ'(1) << win_idx;
      end
   end

   // Operand select for the winning requester.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      s_sel = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDW'(i)) begin
            a_sel = op_a[i*WIDTH +: WIDTH];
            b_sel = op_b[i*WIDTH +: WIDTH];
            s_sel = sub[i];
         end
      end
   end

   // Shared adder: subtract as A + ~B + 1, carry-out doubles as no-borrow.
   always_comb begin
      b_mod = s_sel ? ~b_sel : b_sel;
      full  = {1'b0, a_sel}
            + {1'b0, b_mod}
            + {{WIDTH{1'b0}}, s_sel};
      ovf_c = (a_sel[WIDTH-1] == b_mod[WIDTH-1])
           && (full[WIDTH-1] != a_sel[WIDTH-1]);
   end

   // Next state: a new grant loads, an accept without grant clears valid.
   always_comb begin
      ptr_d   = ptr_q;
      valid_d = valid_q;
      id_d    = id_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (grant_en) begin
         valid_d = 1'b1;
         id_d    = win_idx;
         sum_d   = full[WIDTH-1:0];
         cout_d  = full[WIDTH];
         ovf_d   = ovf_c;
         if (win_idx == IDW'(NUM_REQ-1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win_idx + IDW'(1);
         end
      end else if (valid_q && rsp_ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers; reset drops any pending result without handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign rsp_valid = valid_q;
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign rsp_ovf   = ovf_q;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one WIDTH-bit adder/subtractor between NUM_REQ requesters in the SurvivorCore datapath. A round-robin arbiter picks one pending request per cycle, computes the sum or difference, and holds the result in a single output register until the consumer accepts it. The block sits between the core's add-using units (ALU, address generation, branch target) and the shared adder. It serialises their accesses without starvation.

## Interface
- WIDTH, 32, operand and result width in bits.
- NUM_REQ, 4, number of requesters; must be ≥ 2. IDW = $clog2(NUM_REQ).

- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- req  in  NUM_REQ  request i pending; held high with operands stable until grant[i].
- op_a  in  NUM_REQ*WIDTH  operand A of requester i, bits [i*WIDTH +: WIDTH].
- op_b  in  NUM_REQ*WIDTH  operand B of requester i, same packing.
- sub  in  NUM_REQ  1 = A − B, 0 = A + B, for requester i.
- grant  out  NUM_REQ  one-hot or zero; combinational; grant[i] = request i accepted this cycle.
- rsp_valid  out  1  result register holds an unconsumed result.
- rsp_ready  in  1  consumer accepts the result this cycle.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  WIDTH  result, modulo 2^WIDTH.
- rsp_cout  out  1  carry out of bit WIDTH−1. For subtraction this is "no borrow".
- rsp_ovf  out  1  two's-complement signed overflow.

## Operation
- Slot free: `free = !rsp_valid || rsp_ready`.
- Grant: when free is high, reset is low, and req is nonzero, exactly one grant bit is set. The winner is the first set req bit found scanning upward from ptr, wrapping NUM_REQ−1 → 0. Otherwise grant = 0.
- Round-robin pointer: ptr is IDW bits and resets to 0. On a grant to requester w, ptr ← (w+1) mod NUM_REQ. Otherwise ptr holds. A requester therefore waits at most NUM_REQ−1 grants.
- Arithmetic on the granted requester w:
  - b' = sub[w] ? ~op_b[w] : op_b[w].
  - {cout, sum} = op_a[w] + b' + sub[w], computed in WIDTH+1 bits.
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
- Output register update, in priority order:
  - On a grant: rsp_valid ← 1 and rsp_id/sum/cout/ovf ← the winner's values.
  - Else, if rsp_valid && rsp_ready: rsp_valid ← 0. The data fields hold their last values.
  - Otherwise the register holds.
- Backpressure: while rsp_valid && !rsp_ready, no grant is issued, and rsp_* remain stable until accepted.
- Reset state: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, ptr=0. grant=0 while reset is high, regardless of req.
- Reset mid-operation: any pending result is discarded with no handshake. Requests not yet granted stay pending and are arbitrated from ptr=0 after reset falls.
- Requests are not checked: a req deasserted before its grant is simply dropped. Operand changes before grant are legal; operands are sampled only in the grant cycle.

## Timing
- Latency: grant in cycle N → rsp_valid=1 with the result after the edge ending cycle N. Consumer sees it in cycle N+1.
- Throughput: one result per cycle while rsp_ready stays high. Grant and acceptance may coincide in the same cycle, so the register is reloaded with no bubble.
- The grant path is purely combinational from req, ptr, rsp_valid, rsp_ready and reset. Requesters must not make req depend combinationally on grant.
- The only architectural state is ptr plus the output register.

## Test plan
- Reset and single add:
  - Hold reset 3 cycles with req=4'b1111: grant=0 and all rsp_*=0 throughout.
  - After release, req[2]=1 with A=5, B=7, sub=0, rsp_ready=1.
  - Expect grant=4'b0100 that cycle; next cycle rsp_valid=1, rsp_id=2, rsp_sum=12, cout=0, ovf=0.
- Round-robin fairness: req=4'b1111 held continuously with rsp_ready=1. Grants follow the order 0,1,2,3,0,1 in consecutive cycles, and rsp_id shows the same sequence one cycle later.
- Subtract, carry and overflow:
  - 0x00000003 − 0x00000005 → sum 0xFFFFFFFE, cout=0, ovf=0.
  - 0x7FFFFFFF + 1 → sum 0x80000000, cout=0, ovf=1.
  - 0xFFFFFFFF + 1 → sum 0, cout=1, ovf=0.
  - 0x80000000 − 1 → sum 0x7FFFFFFF, cout=1, ovf=1.
- Backpressure:
  - Issue a grant to req[1]; rsp_ready=0 for 4 cycles while req[3] is pending.
  - Expect grant=0 and rsp_* stable (id=1) for those 4 cycles.
  - Raise rsp_ready: grant[3] is asserted in the same cycle, and the next cycle shows rsp_id=3.
- Pointer wrap and skip:
  - Grant requester 3 so ptr wraps to 0; then req=4'b0110 → grant[1], then grant[2].
  - With req=4'b0001 and ptr=2 → grant[0].
- Reset mid-operation: set rsp_valid=1 (unaccepted) and ptr=3, then pulse reset for 1 cycle with req=4'b1010. After reset: rsp_valid=0, and the next grant goes to requester 1 (ptr=0), not 3.
